// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared constants for the MIPS run-control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam logic [2:0] MODE_HALT  = 3'b000;
    localparam logic [2:0] MODE_RUN   = 3'b001;
    localparam logic [2:0] MODE_STEP  = 3'b010;
    localparam logic [2:0] MODE_BPRUN = 3'b011;

    // Breakpoints compare word addresses, so the byte offset bits are dropped
    localparam int BP_PC_HI = 17;
    localparam int BP_PC_LO = 2;
    localparam int BP_W     = BP_PC_HI - BP_PC_LO + 1;

    function automatic logic mode_is_halt(input logic [2:0] m);
        return (m == MODE_HALT) || m[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/step_debounce.sv
// ============================================================================
//  Module      : step_debounce
//  Description : Synchronizer, stability filter and rising-edge detect for the
//                single-step push button.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic step_btn,
    output logic step_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q, filt_prev_d;

    always_comb begin
        sync1_d     = step_btn;
        sync2_d     = sync1_q;
        last_d      = sync2_q;
        filt_prev_d = filt_q;
        cnt_d       = cnt_q;
        filt_d      = filt_q;
        // Any movement of the synchronized level restarts the stability window
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            filt_d = last_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
        end
    end

    assign step_pulse = filt_q & ~filt_prev_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Run-control sequencer producing the core clock enable for
//                halt / run / single-step / run-to-breakpoint operation.
//                Breakpoint support is built only when RUN_CTRL_BP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [2:0]        mode,
    input  logic              step_btn,
    input  logic [15:0]       bp_addr,
    input  logic [31:0]       pc,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt
);

    logic             w_step_pulse;
    logic             w_bp_stop;
    logic             w_mode_go;
    logic             w_unused_bits;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .step_btn   (step_btn),
        .step_pulse (w_step_pulse)
    );

`ifdef RUN_CTRL_BP_EN
    assign w_bp_stop     = (mode == MODE_BPRUN) && (pc[BP_PC_HI:BP_PC_LO] == bp_addr[BP_W-1:0]);
    assign w_unused_bits = &{1'b0, pc[31:BP_PC_HI+1], pc[BP_PC_LO-1:0]};
`else
    assign w_bp_stop     = 1'b0;
    assign w_unused_bits = &{1'b0, pc, bp_addr};
`endif

    assign w_mode_go = (mode == MODE_RUN) || (mode == MODE_BPRUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (w_mode_go)
                    state_d = ST_RUN;
                else if ((mode == MODE_STEP) && w_step_pulse)
                    state_d = ST_STEP;
            end
            ST_RUN: begin
                if (!w_mode_go)
                    state_d = ST_HALT;
                else if (w_bp_stop)
                    state_d = ST_BREAK;
            end
            ST_STEP: state_d = ST_HALT;
            ST_BREAK: begin
                // Staying in BPRUN parks here; only HALT or a step releases it
                if (mode_is_halt(mode))
                    state_d = ST_HALT;
                else if ((mode == MODE_STEP) && w_step_pulse)
                    state_d = ST_STEP;
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign cpu_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && !w_bp_stop);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cpu_en)
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_HALT;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
    assign bp_hit    = (state_q == ST_BREAK);
    assign cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
//  Module      : tb_cpu_run_ctrl
//  Description : Self-checking bench for cpu_run_ctrl (directed scenarios plus
//                a randomized run against a behavioural model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_run_ctrl;

`ifdef RUN_CTRL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  mode;
    logic        step_btn;
    logic [15:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int en_seen  = 0;
    bit pc_track = 1'b0;
    bit saw_step = 1'b0;
    int exp_cnt  = 0;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (32)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mode      (mode),
        .step_btn  (step_btn),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // One clock: sample at the falling edge, let the fetch stage advance pc
    task automatic tick();
        bit en_s;
        @(negedge sys_clk);
        en_s = cpu_en;
        if (cpu_en) en_seen++;
        if (state == 2'd2) saw_step = 1'b1;
        @(posedge sys_clk);
        #1;
        if (pc_track && en_s) pc = pc + 32'd4;
    endtask

    task automatic press(input int bounce);
        for (int i = 0; i < bounce; i++) begin
            step_btn = ~i[0];
            tick();
        end
        step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; mode = 3'b000; step_btn = 1'b0; bp_addr = 16'h0; pc = 32'h0;
        repeat (2) tick();
        n_checks += 5;
        if (state !== 2'd0)     begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        if (cpu_en !== 1'b0)    begin n_fail++; $display("FAIL reset_en: got %0b want 0", cpu_en); end
        if (halted !== 1'b1)    begin n_fail++; $display("FAIL reset_halted: got %0b want 1", halted); end
        if (bp_hit !== 1'b0)    begin n_fail++; $display("FAIL reset_bp_hit: got %0b want 0", bp_hit); end
        if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
        @(negedge sys_clk); sys_rst = 1'b0;
        tick();
        mode = 3'b001;
        repeat (3) tick();
        n_checks++;
        if (cpu_en !== 1'b1)    begin n_fail++; $display("FAIL pre_reset_running: got %0b want 1", cpu_en); end
        #2 sys_rst = 1'b1;
        #1;
        n_checks += 4;
        if (cpu_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_en: got %0b want 0", cpu_en); end
        if (halted !== 1'b1)    begin n_fail++; $display("FAIL midrst_halted: got %0b want 1", halted); end
        if (state !== 2'd0)     begin n_fail++; $display("FAIL midrst_state: got %0d want 0", state); end
        if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", cycle_cnt); end
        mode = 3'b000;
        @(negedge sys_clk); sys_rst = 1'b0;
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_free_run();
        int e0;
        e0 = en_seen;
        mode = 3'b001;
        repeat (10) tick();
        mode = 3'b000;
        repeat (5) tick();
        exp_cnt += 10;
        n_checks += 3;
        if (en_seen - e0 !== 10)     begin n_fail++; $display("FAIL run_en_cycles: got %0d want 10", en_seen - e0); end
        if (cycle_cnt !== exp_cnt)   begin n_fail++; $display("FAIL run_cnt: got %0d want %0d", cycle_cnt, exp_cnt); end
        if (state !== 2'd0)          begin n_fail++; $display("FAIL run_state: got %0d want 0", state); end
    endtask

    task automatic test_step();
        int e0;
        e0 = en_seen;
        saw_step = 1'b0;
        mode = 3'b010;
        press(3);
        exp_cnt += 1;
        n_checks += 4;
        if (en_seen - e0 !== 1)    begin n_fail++; $display("FAIL step_en_cycles: got %0d want 1", en_seen - e0); end
        if (saw_step !== 1'b1)     begin n_fail++; $display("FAIL step_seen: got %0b want 1", saw_step); end
        if (cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL step_cnt: got %0d want %0d", cycle_cnt, exp_cnt); end
        if (state !== 2'd0)        begin n_fail++; $display("FAIL step_state: got %0d want 0", state); end
        mode = 3'b000;
    endtask

    task automatic test_breakpoint_and_step_over();
        int guard;
        int e0;
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        bp_addr = 16'h0005; pc = 32'h0; pc_track = 1'b1;
        mode = 3'b011;
        guard = 0;
        while (pc != 32'h14 && guard < 20) begin tick(); guard++; end
        n_checks++;
        if (pc != 32'h14) begin n_fail++; $display("FAIL bp_reach_pc: got %0h want 14", pc); end
        @(negedge sys_clk);
        n_checks += 2;
        if (cpu_en !== !BP_EN)      begin n_fail++; $display("FAIL bp_zero_latency_en: got %0b want %0b", cpu_en, !BP_EN); end
        if (cycle_cnt !== 32'd5)    begin n_fail++; $display("FAIL bp_cnt_at_match: got %0d want 5", cycle_cnt); end
        @(posedge sys_clk); #1;
        tick();
        repeat (2) tick();
        n_checks += 4;
        if (state !== (BP_EN ? 2'd3 : 2'd1))         begin n_fail++; $display("FAIL bp_state: got %0d want %0d", state, BP_EN ? 3 : 1); end
        if (bp_hit !== BP_EN)                        begin n_fail++; $display("FAIL bp_hit: got %0b want %0b", bp_hit, BP_EN); end
        if (halted !== BP_EN)                        begin n_fail++; $display("FAIL bp_halted: got %0b want %0b", halted, BP_EN); end
        if (cycle_cnt !== (BP_EN ? 32'd5 : 32'd9))   begin n_fail++; $display("FAIL bp_cnt_hold: got %0d want %0d", cycle_cnt, BP_EN ? 5 : 9); end
        e0 = en_seen;
        mode = 3'b010;
        press(0);
        n_checks += 4;
        if (en_seen - e0 !== (BP_EN ? 1 : 2))        begin n_fail++; $display("FAIL stepover_en_cycles: got %0d want %0d", en_seen - e0, BP_EN ? 1 : 2); end
        if (cycle_cnt !== (BP_EN ? 32'd6 : 32'd11))  begin n_fail++; $display("FAIL stepover_cnt: got %0d want %0d", cycle_cnt, BP_EN ? 6 : 11); end
        if (state !== 2'd0)                          begin n_fail++; $display("FAIL stepover_state: got %0d want 0", state); end
        if (bp_hit !== 1'b0)                         begin n_fail++; $display("FAIL stepover_bp_hit: got %0b want 0", bp_hit); end
        mode = 3'b000; pc_track = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        mode = 3'b000;
        @(negedge sys_clk);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        @(posedge sys_clk); #1;
        release dut.cycle_cnt_q;
        tick();
        n_checks++;
        if (cycle_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %0h want ffffffff", cycle_cnt); end
        mode = 3'b001;
        tick();
        mode = 3'b000;
        tick();
        n_checks += 2;
        if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0h want 0", cycle_cnt); end
        if (state !== 2'd0)      begin n_fail++; $display("FAIL wrap_state: got %0d want 0", state); end
    endtask

    // Reference: states HALT=0 RUN=1 STEP=2 BREAK=3; button idle, so STEP is never entered
    task automatic test_random();
        int  m_st;
        int  m_cnt;
        bit  stop_here;
        bit  exp_en;
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        m_st = 0; m_cnt = 0; step_btn = 1'b0;
        for (int i = 0; i < 400; i++) begin
            mode    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            bp_addr = 16'($urandom_range(0, 7));
            pc      = {14'($urandom), 16'($urandom_range(0, 7)), 2'($urandom)};
            stop_here = BP_EN && (mode == 3'd3) && (pc[17:2] == bp_addr);
            exp_en    = (m_st == 2) || (m_st == 1 && !stop_here);
            @(negedge sys_clk);
            n_checks += 5;
            if (cpu_en !== exp_en)               begin n_fail++; $display("FAIL rnd_en[%0d]: got %0b want %0b", i, cpu_en, exp_en); end
            if (state !== 2'(m_st))              begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_st); end
            if (halted !== (m_st == 0 || m_st == 3)) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %0b", i, halted); end
            if (bp_hit !== (m_st == 3))          begin n_fail++; $display("FAIL rnd_bp_hit[%0d]: got %0b", i, bp_hit); end
            if (cycle_cnt !== 32'(m_cnt))        begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cycle_cnt, m_cnt); end
            @(posedge sys_clk); #1;
            m_cnt += int'(exp_en);
            case (m_st)
                0: if (mode == 3'd1 || mode == 3'd3) m_st = 1;
                1: if (mode != 3'd1 && mode != 3'd3) m_st = 0;
                   else if (stop_here)                m_st = 3;
                2: m_st = 0;
                default: if (mode == 3'd0 || mode >= 3'd4) m_st = 0;
            endcase
        end
        mode = 3'b000;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_breakpoint_and_step_over();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
